// File: rtl/ddram_arb.sv
// Round-robin multi-channel front end for the HPS DDR3 Avalon port.
// Grants one client at a time a read or write burst and returns read beats tagged per channel.
module ddram_arb #(
  parameter int          CH     = 2,
  parameter int          ADDR_W = 26,
  parameter logic [28:0] BASE   = 29'h0380_0000
) (
  input  logic                 DDRAM_CLK,
  input  logic                 reset,
  input  logic                 DDRAM_BUSY,
  output logic [7:0]           DDRAM_BURSTCNT,
  output logic [28:0]          DDRAM_ADDR,
  input  logic [63:0]          DDRAM_DOUT,
  input  logic                 DDRAM_DOUT_READY,
  output logic                 DDRAM_RD,
  output logic [63:0]          DDRAM_DIN,
  output logic [7:0]           DDRAM_BE,
  output logic                 DDRAM_WE,
  input  logic [CH-1:0]        ch_req,
  input  logic [CH-1:0]        ch_we,
  input  logic [CH*ADDR_W-1:0] ch_addr,
  input  logic [CH*8-1:0]      ch_burst,
  input  logic [CH*64-1:0]     ch_din,
  input  logic [CH*8-1:0]      ch_be,
  output logic [CH-1:0]        ch_ack,
  output logic [CH-1:0]        ch_wnext,
  output logic [63:0]          ch_dout,
  output logic [CH-1:0]        ch_dready,
  output logic [CH-1:0]        ch_done,
  output logic [CH-1:0]        ch_busy
);

  localparam int GW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       last_q, last_d;
  logic [GW-1:0]       g_q, g_d;
  logic [28:0]         addr_q, addr_d;
  logic [7:0]          burst_q, burst_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                rd_q, rd_d;
  logic                we_q, we_d;
  logic [CH-1:0]       ack_q, ack_d;
  logic [CH-1:0]       dready_q, dready_d;
  logic [CH-1:0]       done_q, done_d;
  logic [63:0]         dout_q, dout_d;

  logic [ADDR_W-1:0]   addr_a  [CH];
  logic [7:0]          burst_a [CH];
  logic [63:0]         din_a   [CH];
  logic [7:0]          be_a    [CH];

  for (genvar c = 0; c < CH; c++) begin : g_unpack
    assign addr_a[c]  = ch_addr[c*ADDR_W +: ADDR_W];
    assign burst_a[c] = ch_burst[c*8 +: 8];
    assign din_a[c]   = ch_din[c*64 +: 64];
    assign be_a[c]    = ch_be[c*8 +: 8];
  end

  // Round-robin pick: first requester at or after last_grant+1.
  logic          sel_found;
  logic [GW-1:0] sel_idx;
  logic [GW-1:0] rr_idx;
  logic [7:0]    sel_burst;
  logic [28:0]   sel_word;

  always_comb begin
    // NOTE: every combinationally written signal gets a default first so no latch is inferred.
    sel_found = 1'b0;
    sel_idx   = '0;
    rr_idx    = '0;
    for (int i = 0; i < CH; i++) begin
      rr_idx = GW'((int'(last_q) + 1 + i) % CH);
      if (!sel_found && ch_req[rr_idx]) begin
        sel_found = 1'b1;
        sel_idx   = rr_idx;
      end
    end
    sel_burst = (burst_a[sel_idx] == 8'd0) ? 8'd1 : burst_a[sel_idx];
    sel_word  = BASE + 29'(addr_a[sel_idx] >> 3);
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    g_d      = g_q;
    addr_d   = addr_q;
    burst_d  = burst_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    we_d     = we_q;
    ack_d    = '0;
    dready_d = '0;
    done_d   = '0;
    dout_d   = dout_q;
    unique case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          g_d          = sel_idx;
          last_d       = sel_idx;
          addr_d       = sel_word;
          burst_d      = sel_burst;
          cnt_d        = sel_burst;
          ack_d[sel_idx] = 1'b1;
          we_d         = ch_we[sel_idx];
          rd_d         = !ch_we[sel_idx];
          state_d      = ch_we[sel_idx] ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (we_q && !DDRAM_BUSY) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            done_d[g_q] = 1'b1;
            we_d        = 1'b0;
            state_d     = S_IDLE;
          end
        end
      end
      S_READ: begin
        if (rd_q && !DDRAM_BUSY) rd_d = 1'b0;
        if (DDRAM_DOUT_READY) begin
          dout_d        = DDRAM_DOUT;
          dready_d[g_q] = 1'b1;
          cnt_d         = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            done_d[g_q] = 1'b1;
            rd_d        = 1'b0;
            state_d     = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge DDRAM_CLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q  <= S_IDLE;
      last_q   <= GW'(CH - 1);
      g_q      <= '0;
      addr_q   <= '0;
      burst_q  <= 8'd1;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      we_q     <= 1'b0;
      ack_q    <= '0;
      dready_q <= '0;
      done_q   <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      g_q      <= g_d;
      addr_q   <= addr_d;
      burst_q  <= burst_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      ack_q    <= ack_d;
      dready_q <= dready_d;
      done_q   <= done_d;
      dout_q   <= dout_d;
    end
  end

  // Write data and the beat-accept strobe follow the granted client combinationally.
  always_comb begin
    ch_wnext = '0;
    ch_busy  = '0;
    if (we_q && !DDRAM_BUSY) ch_wnext[g_q] = 1'b1;
    if (state_q != S_IDLE)   ch_busy[g_q]  = 1'b1;
  end

  assign DDRAM_RD       = rd_q;
  assign DDRAM_WE       = we_q;
  assign DDRAM_ADDR     = addr_q;
  assign DDRAM_BURSTCNT = burst_q;
  assign DDRAM_DIN      = we_q ? din_a[g_q] : 64'd0;
  assign DDRAM_BE       = we_q ? be_a[g_q] : 8'hFF;
  assign ch_ack         = ack_q;
  assign ch_dready      = dready_q;
  assign ch_done        = done_q;
  assign ch_dout        = dout_q;

endmodule

// File: tb/tb_ddram_arb.sv
// Directed self-checking bench for ddram_arb: grant, read, stalled write, round-robin,
// zero burst, reset mid-read and address wrap (second instance with a high BASE).
module tb_ddram_arb;
  localparam int CH = 2;
  localparam int AW = 26;

  logic DDRAM_CLK = 1'b0;
  always #5 DDRAM_CLK = ~DDRAM_CLK;

  logic             reset;
  logic             DDRAM_BUSY;
  logic [7:0]       DDRAM_BURSTCNT;
  logic [28:0]      DDRAM_ADDR;
  logic [63:0]      DDRAM_DOUT;
  logic             DDRAM_DOUT_READY;
  logic             DDRAM_RD;
  logic [63:0]      DDRAM_DIN;
  logic [7:0]       DDRAM_BE;
  logic             DDRAM_WE;
  logic [CH-1:0]    ch_req, ch_we;
  logic [CH*AW-1:0] ch_addr;
  logic [CH*8-1:0]  ch_burst;
  logic [CH*64-1:0] ch_din;
  logic [CH*8-1:0]  ch_be;
  logic [CH-1:0]    ch_ack, ch_wnext, ch_dready, ch_done, ch_busy;
  logic [63:0]      ch_dout;

  // Second instance: one channel, base close to 2^29 to exercise wrap-around.
  logic        w_busy, w_burstcnt_dummy_unused;
  logic [7:0]  w_burstcnt;
  logic [28:0] w_addr_out;
  logic [63:0] w_dout_in, w_din_out, w_din, w_dout;
  logic        w_ready, w_rd, w_we_out, w_req, w_we;
  logic [7:0]  w_be_out, w_burst, w_be;
  logic [AW-1:0] w_addr;
  logic        w_ack, w_wnext, w_dready, w_done, w_chbusy;

  ddram_arb #(.CH(CH), .ADDR_W(AW), .BASE(29'h0380_0000)) u_dut (
    .DDRAM_CLK(DDRAM_CLK), .reset(reset), .DDRAM_BUSY(DDRAM_BUSY),
    .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DOUT(DDRAM_DOUT),
    .DDRAM_DOUT_READY(DDRAM_DOUT_READY), .DDRAM_RD(DDRAM_RD), .DDRAM_DIN(DDRAM_DIN),
    .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE), .ch_req(ch_req), .ch_we(ch_we),
    .ch_addr(ch_addr), .ch_burst(ch_burst), .ch_din(ch_din), .ch_be(ch_be),
    .ch_ack(ch_ack), .ch_wnext(ch_wnext), .ch_dout(ch_dout), .ch_dready(ch_dready),
    .ch_done(ch_done), .ch_busy(ch_busy)
  );

  ddram_arb #(.CH(1), .ADDR_W(AW), .BASE(29'h1FFF_FFF0)) u_wrap (
    .DDRAM_CLK(DDRAM_CLK), .reset(reset), .DDRAM_BUSY(w_busy),
    .DDRAM_BURSTCNT(w_burstcnt), .DDRAM_ADDR(w_addr_out), .DDRAM_DOUT(w_dout_in),
    .DDRAM_DOUT_READY(w_ready), .DDRAM_RD(w_rd), .DDRAM_DIN(w_din_out),
    .DDRAM_BE(w_be_out), .DDRAM_WE(w_we_out), .ch_req(w_req), .ch_we(w_we),
    .ch_addr(w_addr), .ch_burst(w_burst), .ch_din(w_din), .ch_be(w_be),
    .ch_ack(w_ack), .ch_wnext(w_wnext), .ch_dout(w_dout), .ch_dready(w_dready),
    .ch_done(w_done), .ch_busy(w_chbusy)
  );

  int passed = 0;
  int total  = 0;

  task automatic edge_step();
    @(posedge DDRAM_CLK);
    #1;
  endtask

  task automatic wait_idle(input string name);
    bit idle = 1'b0;
    for (int c = 0; c < 12 && !idle; c++) begin
      edge_step();
      if (ch_busy == '0 && !DDRAM_WE && !DDRAM_RD) idle = 1'b1;
    end
    total++; if (idle !== 1'b1) $display("FAIL %s_idle_timeout busy=%b", name, ch_busy); else passed++;
  endtask

  task automatic test_reset();
    repeat (3) edge_step();
    total++; if ({DDRAM_RD, DDRAM_WE} !== 2'b00) $display("FAIL rst_rd_we got %b want 00", {DDRAM_RD, DDRAM_WE}); else passed++;
    total++; if (DDRAM_BURSTCNT !== 8'd1) $display("FAIL rst_burstcnt got %0d want 1", DDRAM_BURSTCNT); else passed++;
    total++; if (DDRAM_BE !== 8'hFF) $display("FAIL rst_be got %h want ff", DDRAM_BE); else passed++;
    total++; if (DDRAM_ADDR !== 29'd0) $display("FAIL rst_addr got %h want 0", DDRAM_ADDR); else passed++;
    total++; if ({ch_ack, ch_dready, ch_done, ch_busy, ch_wnext} !== '0) $display("FAIL rst_ch_outputs got %b want 0", {ch_ack, ch_dready, ch_done, ch_busy, ch_wnext}); else passed++;
    total++; if ({ch_dout, DDRAM_DIN} !== 128'd0) $display("FAIL rst_data got %h want 0", {ch_dout, DDRAM_DIN}); else passed++;
    reset = 1'b0;
    edge_step();
    total++; if (ch_ack !== 2'b00) $display("FAIL idle_no_ack got %b want 00", ch_ack); else passed++;
  endtask

  task automatic test_read();
    logic [63:0] rdata [4];
    rdata[0] = 64'h0123_4567_89AB_CDEF; rdata[1] = 64'hFEDC_BA98_7654_3210;
    rdata[2] = 64'h5555_AAAA_0000_FFFF; rdata[3] = 64'h1111_2222_3333_4444;
    ch_addr[0 +: AW] = 26'h000100;
    ch_burst[7:0]    = 8'd4;
    ch_we[0]         = 1'b0;
    ch_req[0]        = 1'b1;
    edge_step();
    total++; if (ch_ack !== 2'b01) $display("FAIL rd_ack got %b want 01", ch_ack); else passed++;
    total++; if (DDRAM_RD !== 1'b1) $display("FAIL rd_rd got %b want 1", DDRAM_RD); else passed++;
    total++; if (DDRAM_ADDR !== 29'h0380_0020) $display("FAIL rd_addr got %h want 3800020", DDRAM_ADDR); else passed++;
    total++; if (DDRAM_BURSTCNT !== 8'd4) $display("FAIL rd_burstcnt got %0d want 4", DDRAM_BURSTCNT); else passed++;
    ch_req[0] = 1'b0;
    edge_step();
    total++; if ({DDRAM_RD, ch_busy} !== 3'b001) $display("FAIL rd_cmd_drop got %b want 001", {DDRAM_RD, ch_busy}); else passed++;
    for (int k = 0; k < 4; k++) begin
      DDRAM_DOUT       = rdata[k];
      DDRAM_DOUT_READY = 1'b1;
      edge_step();
      total++; if (ch_dready !== 2'b01) $display("FAIL rd_dready%0d got %b want 01", k, ch_dready); else passed++;
      total++; if (ch_dout !== rdata[k]) $display("FAIL rd_dout%0d got %h want %h", k, ch_dout, rdata[k]); else passed++;
      total++; if (ch_done !== ((k == 3) ? 2'b01 : 2'b00)) $display("FAIL rd_done%0d got %b", k, ch_done); else passed++;
    end
    DDRAM_DOUT_READY = 1'b0;
    edge_step();
    total++; if ({ch_dready, ch_busy} !== 4'b0000) $display("FAIL rd_end got %b want 0000", {ch_dready, ch_busy}); else passed++;
  endtask

  task automatic test_write_stall();
    logic [63:0] wdata [4];
    logic [7:0]  wbe [4];
    int idx = 0, stall = 0, cyc = -1;
    bit wn;
    wdata[0] = 64'hA0A0_0000_0000_0001; wdata[1] = 64'hB1B1_0000_0000_0002;
    wdata[2] = 64'hC2C2_0000_0000_0003; wdata[3] = 64'd0;
    wbe[0] = 8'h0F; wbe[1] = 8'hF0; wbe[2] = 8'h3C; wbe[3] = 8'h00;
    ch_addr[AW +: AW] = 26'h000200;
    ch_burst[15:8]    = 8'd3;
    ch_we[1]          = 1'b1;
    ch_din[127:64]    = wdata[0];
    ch_be[15:8]       = wbe[0];
    ch_req[1]         = 1'b1;
    edge_step();
    total++; if ({ch_ack, DDRAM_WE} !== 3'b101) $display("FAIL wr_ack_we got %b want 101", {ch_ack, DDRAM_WE}); else passed++;
    total++; if (DDRAM_ADDR !== 29'h0380_0040) $display("FAIL wr_addr got %h want 3800040", DDRAM_ADDR); else passed++;
    total++; if (DDRAM_BURSTCNT !== 8'd3) $display("FAIL wr_burstcnt got %0d want 3", DDRAM_BURSTCNT); else passed++;
    ch_req[1] = 1'b0;
    for (int c = 0; c < 15 && cyc < 0; c++) begin
      DDRAM_BUSY = (idx == 1 && stall < 2);
      if (DDRAM_BUSY) stall++;
      ch_din[127:64] = wdata[idx & 3];
      ch_be[15:8]    = wbe[idx & 3];
      #1;
      total++; if (DDRAM_WE !== 1'b1) $display("FAIL wr_we_held c%0d got %b want 1", c, DDRAM_WE); else passed++;
      total++; if ({DDRAM_DIN, DDRAM_BE} !== {wdata[idx & 3], wbe[idx & 3]}) $display("FAIL wr_din c%0d got %h/%h want %h/%h", c, DDRAM_DIN, DDRAM_BE, wdata[idx & 3], wbe[idx & 3]); else passed++;
      total++; if (ch_wnext !== (DDRAM_BUSY ? 2'b00 : 2'b10)) $display("FAIL wr_wnext c%0d got %b busy=%b", c, ch_wnext, DDRAM_BUSY); else passed++;
      wn = ch_wnext[1];
      edge_step();
      if (wn) idx++;
      if (ch_done != '0) begin
        cyc = c + 1;
        total++; if (ch_done !== 2'b10) $display("FAIL wr_done_ch got %b want 10", ch_done); else passed++;
      end
    end
    DDRAM_BUSY = 1'b0;
    total++; if (idx !== 3) $display("FAIL wr_beats got %0d want 3", idx); else passed++;
    total++; if (cyc !== 5) $display("FAIL wr_done_cycle got %0d want 5", cyc); else passed++;
    total++; if (DDRAM_WE !== 1'b0) $display("FAIL wr_we_drop got %b want 0", DDRAM_WE); else passed++;
  endtask

  task automatic test_alternate();
    logic [3:0] seq = '0;
    int n = 0;
    ch_we    = 2'b11;
    ch_burst = {8'd1, 8'd1};
    ch_req   = 2'b11;
    for (int c = 0; c < 40 && n < 4; c++) begin
      edge_step();
      if (ch_ack != '0) begin
        total++; if (!$onehot(ch_ack)) $display("FAIL rr_onehot got %b", ch_ack); else passed++;
        seq[n] = ch_ack[1];
        n++;
      end
    end
    ch_req = 2'b00;
    total++; if (n !== 4) $display("FAIL rr_grants got %0d want 4", n); else passed++;
    total++; if (seq !== 4'b1010) $display("FAIL rr_order got %b want 1010 (lsb first)", seq); else passed++;
    wait_idle("rr");
  endtask

  task automatic test_burst_zero();
    int nw = 0, nd = 0;
    ch_we[0]      = 1'b1;
    ch_burst[7:0] = 8'd0;
    ch_req        = 2'b01;
    edge_step();
    total++; if ({ch_ack, DDRAM_WE} !== 3'b011) $display("FAIL bz_ack_we got %b want 011", {ch_ack, DDRAM_WE}); else passed++;
    total++; if (DDRAM_BURSTCNT !== 8'd1) $display("FAIL bz_burstcnt got %0d want 1", DDRAM_BURSTCNT); else passed++;
    ch_req = 2'b00;
    for (int c = 0; c < 6; c++) begin
      #1;
      nw += $countones(ch_wnext);
      edge_step();
      nd += $countones(ch_done);
      if (c == 0) begin
        total++; if (ch_done !== 2'b01) $display("FAIL bz_done_time got %b want 01", ch_done); else passed++;
      end
    end
    total++; if (nw !== 1) $display("FAIL bz_wnext_count got %0d want 1", nw); else passed++;
    total++; if (nd !== 1) $display("FAIL bz_done_count got %0d want 1", nd); else passed++;
  endtask

  task automatic test_reset_mid_read();
    ch_we            = 2'b00;
    ch_addr[0 +: AW] = 26'h000040;
    ch_burst[7:0]    = 8'd8;
    ch_req           = 2'b01;
    edge_step();
    total++; if (ch_ack !== 2'b01) $display("FAIL mr_ack got %b want 01", ch_ack); else passed++;
    ch_req = 2'b00;
    edge_step();
    for (int k = 0; k < 2; k++) begin
      DDRAM_DOUT       = 64'h100 + 64'(k);
      DDRAM_DOUT_READY = 1'b1;
      edge_step();
      total++; if (ch_dready !== 2'b01) $display("FAIL mr_dready%0d got %b want 01", k, ch_dready); else passed++;
    end
    reset      = 1'b1;
    DDRAM_DOUT = 64'h102;
    edge_step();
    total++; if ({DDRAM_RD, DDRAM_WE, ch_dready, ch_done, ch_busy, ch_ack} !== '0) $display("FAIL mr_rst_ctrl got %b want 0", {DDRAM_RD, DDRAM_WE, ch_dready, ch_done, ch_busy, ch_ack}); else passed++;
    total++; if ({DDRAM_BURSTCNT, DDRAM_BE} !== 16'h01FF) $display("FAIL mr_rst_bus got %h want 01ff", {DDRAM_BURSTCNT, DDRAM_BE}); else passed++;
    total++; if ({DDRAM_ADDR, ch_dout} !== '0) $display("FAIL mr_rst_addr_dout got %h want 0", {DDRAM_ADDR, ch_dout}); else passed++;
    reset = 1'b0;
    for (int k = 3; k < 8; k++) begin
      DDRAM_DOUT = 64'h100 + 64'(k);
      edge_step();
      total++; if ({ch_dready, ch_done} !== 4'b0000) $display("FAIL mr_stray%0d got %b want 0000", k, {ch_dready, ch_done}); else passed++;
    end
    DDRAM_DOUT_READY = 1'b0;
    ch_we    = 2'b11;
    ch_burst = {8'd1, 8'd1};
    ch_req   = 2'b11;
    edge_step();
    total++; if (ch_ack !== 2'b01) $display("FAIL mr_next_grant got %b want 01", ch_ack); else passed++;
    ch_req = 2'b00;
    wait_idle("mr");
  endtask

  task automatic test_wrap();
    w_addr  = '1;
    w_burst = 8'd1;
    w_we    = 1'b0;
    w_req   = 1'b1;
    edge_step();
    total++; if ({w_ack, w_rd} !== 2'b11) $display("FAIL wrap_ack_rd got %b want 11", {w_ack, w_rd}); else passed++;
    total++; if (w_addr_out !== 29'h007F_FFEF) $display("FAIL wrap_addr got %h want 07fffef", w_addr_out); else passed++;
    w_req = 1'b0;
    edge_step();
    w_dout_in = 64'h0000_DEAD_BEEF_0000;
    w_ready   = 1'b1;
    edge_step();
    w_ready = 1'b0;
    total++; if ({w_dready, w_done, w_dout} !== {2'b11, 64'h0000_DEAD_BEEF_0000}) $display("FAIL wrap_beat got %b%b/%h", w_dready, w_done, w_dout); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    DDRAM_BUSY = 1'b0; DDRAM_DOUT = '0; DDRAM_DOUT_READY = 1'b0;
    ch_req = '0; ch_we = '0; ch_addr = '0; ch_burst = '0; ch_din = '0; ch_be = '0;
    w_busy = 1'b0; w_dout_in = '0; w_ready = 1'b0; w_req = 1'b0; w_we = 1'b0;
    w_addr = '0; w_burst = '0; w_din = '0; w_be = '0; w_burstcnt_dummy_unused = 1'b0;
    test_reset();
    test_read();
    test_write_stall();
    test_alternate();
    test_burst_zero();
    test_reset_mid_read();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
